wm_control_panel: RTL
=====================

Name: wm_control_panel

Overview:
Front-panel controller that sits directly upstream of the washing-machine sequencer and drives its start/mode inputs. Synchronises and debounces the raw start and mode buttons and the door switch, and cycles the wash-mode selection. Issues a single-cycle start pulse only when the door is closed. Tracks the sequencer's state code to drive the door lock, busy and done indications.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before a debounced level changes (>=2)
DB_W, 3, debounce counter width; must satisfy 2^DB_W > DEBOUNCE_CYCLES
ARM_TIMEOUT, 8, cycles allowed in ARM for the sequencer to leave IDLE before the panel aborts
TO_W, 4, ARM timeout counter width; must satisfy 2^TO_W > ARM_TIMEOUT

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
btn_start_raw  input  1  raw start pushbutton (asynchronous, bouncy)
btn_mode_raw  input  1  raw mode pushbutton (asynchronous, bouncy)
door_closed_raw  input  1  raw door switch, 1 = closed
machine_state  input  4  sequencer state code: 0000 IDLE, 0001 FILL, 0010 WASH, 0011 RINSE, 0100 SPIN, 0101 DRAIN, 0110 DONE
start  output  1  one-cycle start pulse to the sequencer
mode  output  2  wash mode to the sequencer: 00 light, 01 normal, 10 heavy
door_lock  output  1  door solenoid lock
busy  output  1  cycle in progress
done  output  1  cycle-complete indicator (level)
err_door  output  1  start attempted with door open (level)

Behaviour:
- Reset values: start=0, mode=01, door_lock=0, busy=0, done=0, err_door=0.
  - All synchronisers, debounced levels, counters and prev-level flops reset to 0.
  - FSM resets to P_IDLE.
  - Reset mid-cycle returns everything to these values immediately.
- Synchronisation: each raw input passes through a 2-flop synchroniser.
- Debounce (per input):
  - Counter increments while the synchronised value differs from the debounced level.
  - Counter clears to 0 whenever the two match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the input still differs, the debounced level flips on the next edge and the counter clears.
- Press event: debounced rising edge (db & ~db_prev), combinational, one cycle wide. Falling edges are ignored.
- Latency: with a clean raw step sampled at edge 1, the debounced level changes at edge DEBOUNCE_CYCLES+2 and start goes high after edge DEBOUNCE_CYCLES+3 for exactly one cycle.
- Mode:
  - Mode press in P_IDLE or P_DONE steps 00->01->10->00 (wrap); 11 is never produced.
  - Mode presses in P_ARM or P_RUN are ignored; mode is stable while busy.
- FSM states: P_IDLE, P_ARM, P_RUN, P_DONE.
  - P_IDLE, start press with door_closed sync=1: go to P_ARM and register start=1 for one cycle; err_door clears.
  - P_IDLE, start press with door open: stay in P_IDLE and set err_door=1.
  - P_IDLE, start and mode press in the same cycle: start has priority, the mode press is dropped, and the current mode is used.
  - P_ARM: door_lock=1, busy=1, timeout counter runs.
    - machine_state != 0000 -> P_RUN.
    - Counter reaches ARM_TIMEOUT with machine_state still 0000 -> P_IDLE, lock released, done stays 0.
  - P_RUN: door_lock=1, busy=1.
    - machine_state == 0110 -> P_DONE.
    - machine_state == 0000 without passing 0110 (sequencer reset) -> P_IDLE, no done.
    - Debounced door-open in P_RUN sets err_door=1; state is unchanged.
  - P_DONE: done=1, door_lock=0, busy=0.
    - Any start press, mode press, or debounced door-open -> P_IDLE with done cleared.
    - A start press here is consumed and does not launch a cycle; a mode press here also advances mode.
- err_door clears on:
  - the next successful start;
  - a debounced door close while in P_IDLE.
- Outputs are registered; start is never high for two consecutive cycles.

Test Plan:
- Reset, then start held high 10 cycles, door closed, DEBOUNCE_CYCLES=4 -> start high only in cycle after edge 7, mode=01, door_lock=1 from edge 7.
- btn_start_raw toggles every 2 cycles for 20 cycles -> start never asserts, FSM stays P_IDLE.
- Four clean mode presses in P_IDLE from reset -> mode 10, 00, 01, 10; mode press while busy -> mode unchanged.
- Start press with door open -> err_door=1, start=0. Close door -> err_door=0 after debounce. Start press -> start pulse.
- Full cycle: machine_state 0->1->2->3->4->5->6->0 -> busy 1 through RUN, done=1 and door_lock=0 on 0110, mode press clears done.
- Start pulse with machine_state held 0000 for 9 cycles (ARM_TIMEOUT=8) -> return to P_IDLE, door_lock=0, done=0. Separately, assert reset mid-RUN -> all outputs to reset values at once.

Source files
------------

// File: rtl/wm_control_panel.sv
// wm_control_panel
// Front-panel controller placed in front of the washing-machine sequencer.
// Raw start/mode buttons and the door switch are synchronised and debounced.
// Rising edges of the debounced levels are treated as press events. A start
// press with the door closed launches a cycle with a one-cycle start pulse.
// The panel then follows the sequencer state code to drive the lock, busy
// and done indications.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous active-high reset
//   btn_start_raw   raw start pushbutton (asynchronous, bouncy)
//   btn_mode_raw    raw mode pushbutton (asynchronous, bouncy)
//   door_closed_raw raw door switch, 1 = closed
//   machine_state   sequencer state code (0 IDLE .. 6 DONE)
//   start           one-cycle start pulse to the sequencer
//   mode            wash mode: 00 light, 01 normal, 10 heavy
//   door_lock       door solenoid lock
//   busy            cycle in progress
//   done            cycle-complete level
//   err_door        start attempted or door opened while unsafe (level)
//   o_dbg_state     current panel FSM state, for observation only
module wm_control_panel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = 3,
  parameter int ARM_TIMEOUT     = 8,
  parameter int TO_W            = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_raw,
  input  logic       btn_mode_raw,
  input  logic       door_closed_raw,
  input  logic [3:0] machine_state,
  output logic       start,
  output logic [1:0] mode,
  output logic       door_lock,
  output logic       busy,
  output logic       done,
  output logic       err_door,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_ARM  = 2'd1,
    P_RUN  = 2'd2,
    P_DONE = 2'd3
  } panel_state_t;

  localparam logic [3:0] MS_IDLE = 4'b0000;
  localparam logic [3:0] MS_DONE = 4'b0110;

  // Input lanes: bit 0 start, bit 1 mode, bit 2 door closed.
  logic [2:0]      w_raw;
  logic [2:0]      r_sync1;
  logic [2:0]      r_sync2;
  logic [2:0]      r_db;
  logic [2:0]      r_db_prev;
  logic [DB_W-1:0] r_cnt [3];

  logic [2:0]      w_rise;
  logic [2:0]      w_fall;
  logic            w_start_press;
  logic            w_mode_press;
  logic            w_door_level;
  logic            w_door_close;
  logic            w_door_open;

  panel_state_t    r_state;
  logic            r_start;
  logic [1:0]      r_mode;
  logic            r_lock;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic [TO_W-1:0] r_to_cnt;

  assign w_raw = {door_closed_raw, btn_mode_raw, btn_start_raw};

  // Synchroniser and debounce. The debounced level follows the synchronised
  // input only after it has disagreed for DEBOUNCE_CYCLES consecutive samples;
  // any agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_db      <= '0;
      r_db_prev <= '0;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_db[i]  <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_rise        = r_db & ~r_db_prev;
  assign w_fall        = ~r_db & r_db_prev;
  assign w_start_press = w_rise[0];
  assign w_mode_press  = w_rise[1];
  assign w_door_level  = r_db[2];
  assign w_door_close  = w_rise[2];
  assign w_door_open   = w_fall[2];

  // 00 -> 01 -> 10 -> 00; 11 is never produced.
  function automatic logic [1:0] next_mode(input logic [1:0] m);
    return (m == 2'b10) ? 2'b00 : m + 2'b01;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= P_IDLE;
      r_start  <= 1'b0;
      r_mode   <= 2'b01;
      r_lock   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        P_IDLE: begin
          if (w_door_close) r_err <= 1'b0;
          // Start wins over a simultaneous mode press; the mode press is lost.
          if (w_start_press) begin
            if (w_door_level) begin
              r_state  <= P_ARM;
              r_start  <= 1'b1;
              r_err    <= 1'b0;
              r_lock   <= 1'b1;
              r_busy   <= 1'b1;
              r_to_cnt <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end else if (w_mode_press) begin
            r_mode <= next_mode(r_mode);
          end
        end
        P_ARM: begin
          // Wait for the sequencer to leave IDLE; give up after the timeout.
          if (machine_state != MS_IDLE) begin
            r_state <= P_RUN;
          end else if (r_to_cnt == TO_W'(ARM_TIMEOUT)) begin
            r_state <= P_IDLE;
            r_lock  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        P_RUN: begin
          if (w_door_open) r_err <= 1'b1;
          if (machine_state == MS_DONE) begin
            r_state <= P_DONE;
            r_lock  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (machine_state == MS_IDLE) begin
            // Sequencer went back to IDLE without finishing.
            r_state <= P_IDLE;
            r_lock  <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        P_DONE: begin
          // Any interaction acknowledges completion; a start here only
          // acknowledges and never launches a new cycle.
          if (w_start_press || w_mode_press || w_door_open) begin
            r_state <= P_IDLE;
            r_done  <= 1'b0;
            if (w_mode_press && !w_start_press) r_mode <= next_mode(r_mode);
          end
        end
        default: r_state <= P_IDLE;
      endcase
    end
  end

  assign start       = r_start;
  assign mode        = r_mode;
  assign door_lock   = r_lock;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err_door    = r_err;
  assign o_dbg_state = r_state;

endmodule
